// File: rtl/mux_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module  : mux_tree_pipe
// Brief   : Pipelined N:1 mux tree, one register stage per 2:1 level, with
//           valid/ready flow control. Optional MUXTREE_PARITY_EN adds out_par.
// Revision: 1.0 - initial release
// ============================================================================
module mux_tree_pipe #(
  parameter int WIDTH  = 8,
  parameter int SEL_W  = 3,
  localparam int NUM_IN = 1 << SEL_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MUXTREE_PARITY_EN
  ,output logic                   out_par
`endif
);

  localparam int LAST = SEL_W - 1;

  logic [SEL_W-1:0] valid;
  logic [SEL_W:0]   ready;

  // Ready ripples combinationally from the consumer back to the producer.
  always_comb begin
    ready[SEL_W] = out_ready;
    for (int k = SEL_W - 1; k >= 0; k--) begin
      ready[k] = !valid[k] || ready[k+1];
    end
  end

  for (genvar k = 0; k < SEL_W; k++) begin : g_stage
    localparam int NPREV = 1 << (SEL_W - k);
    localparam int NCAND = NPREV / 2;

    logic [NPREV*WIDTH-1:0] prev_data;
    logic [SEL_W-1:0]       prev_sel;
    logic                   prev_valid;
    logic [NCAND*WIDTH-1:0] nxt;
    logic [NCAND*WIDTH-1:0] cand;
    logic [SEL_W-1:0]       sel;
    logic                   vld;

    if (k == 0) begin : g_src_in
      assign prev_data  = in_data;
      assign prev_sel   = in_sel;
      assign prev_valid = in_valid;
    end else begin : g_src_stage
      assign prev_data  = g_stage[k-1].cand;
      assign prev_sel   = g_stage[k-1].sel;
      assign prev_valid = g_stage[k-1].vld;
    end

    // Select bit k picks between each adjacent candidate pair.
    always_comb begin
      nxt = '0;
      for (int j = 0; j < NCAND; j++) begin
        nxt[j*WIDTH +: WIDTH] = prev_sel[k] ? prev_data[(2*j+1)*WIDTH +: WIDTH]
                                            : prev_data[(2*j)*WIDTH +: WIDTH];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld  <= 1'b0;
        cand <= '0;
        sel  <= '0;
      end else if (ready[k]) begin
        vld <= prev_valid;
        if (prev_valid) begin
          cand <= nxt;
          sel  <= prev_sel;
        end
      end
    end

    assign valid[k] = vld;
  end

  assign in_ready  = ready[0];
  assign out_data  = g_stage[LAST].cand;
  assign out_sel   = g_stage[LAST].sel;
  assign out_valid = g_stage[LAST].vld;

`ifdef MUXTREE_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_par <= 1'b0;
    end else if (ready[LAST] && g_stage[LAST].prev_valid) begin
      out_par <= ^g_stage[LAST].nxt;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_mux_tree_pipe
// Brief   : Directed self-checking bench for mux_tree_pipe (WIDTH=8, SEL_W=3).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mux_tree_pipe;

  localparam int WIDTH = 8;
  localparam int SEL_W = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [8*WIDTH-1:0]  in_data;
  logic [SEL_W-1:0]    in_sel;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    out_data;
  logic [SEL_W-1:0]    out_sel;
  logic                out_valid;
  logic                out_ready;
`ifdef MUXTREE_PARITY_EN
  logic                out_par;
`endif

  int total = 0;
  int bad   = 0;

  mux_tree_pipe #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUXTREE_PARITY_EN
    ,.out_par  (out_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel i carries base + i.
  function automatic logic [8*WIDTH-1:0] pack(input logic [7:0] base);
    logic [8*WIDTH-1:0] v;
    for (int i = 0; i < 8; i++) v[i*WIDTH +: WIDTH] = base + 8'(i);
    return v;
  endfunction

  // Back-pressure beat b: channel base (b+1)<<4, select b%8.
  function automatic logic [7:0] bp_exp(input int b);
    return 8'(((b + 1) << 4) | (b % 8));
  endfunction

  int idx;
  int rcv;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset / idle
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'h00);
    check("rst_out_sel",   32'(out_sel),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef MUXTREE_PARITY_EN
    check("rst_out_par",   32'(out_par),   32'd0);
`endif

    // Channel sweep: beat driven in cycle t shows up in cycle t+3
    for (int t = 0; t < 10; t++) begin
      if (t < 8) begin
        in_valid = 1'b1;
        in_sel   = 3'(t);
        in_data  = pack(8'h10);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (t < 2) begin
        check("sweep_lead_valid", 32'(out_valid), 32'd0);
      end else begin
        check("sweep_valid", 32'(out_valid), 32'd1);
        check("sweep_data",  32'(out_data),  32'(8'h10 + 8'(t - 2)));
        check("sweep_sel",   32'(out_sel),   32'(t - 2));
      end
    end
    tick();
    check("sweep_drained", 32'(out_valid), 32'd0);

    // Back-pressure: fill with consumer stalled
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_sel   = 3'(idx % 8);
      in_data  = pack(8'((idx + 1) << 4));
      #1;
      if (in_ready) idx++;
      tick();
    end
    #1;
    check("bp_accepted",  32'(idx),       32'd3);
    check("bp_in_ready",  32'(in_ready),  32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_frozen0",   32'(out_data),  32'(bp_exp(0)));
    tick();
    tick();
    check("bp_frozen1",   32'(out_data),  32'(bp_exp(0)));
    check("bp_frozen_sel", 32'(out_sel),  32'd0);
    check("bp_still_full", 32'(in_ready), 32'd0);

    out_ready = 1'b1;
    rcv = 0;
    for (int c = 0; c < 60 && rcv < 10; c++) begin
      if (idx < 10) begin
        in_valid = 1'b1;
        in_sel   = 3'(idx % 8);
        in_data  = pack(8'((idx + 1) << 4));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        check("bp_data", 32'(out_data), 32'(bp_exp(rcv)));
        check("bp_sel",  32'(out_sel),  32'(rcv % 8));
        rcv++;
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    check("bp_all_received", 32'(rcv), 32'd10);
    check("bp_all_sent",     32'(idx), 32'd10);
    #1;
    check("bp_empty", 32'(out_valid), 32'd0);

    // Per-beat select follows the beat, not the current input
    for (int t = 0; t < 5; t++) begin
      in_valid = (t < 3);
      case (t)
        0: begin in_sel = 3'd7; in_data = pack(8'hA0); end
        1: begin in_sel = 3'd0; in_data = pack(8'hB0); end
        2: begin in_sel = 3'd5; in_data = pack(8'hC0); end
        default: begin in_sel = 3'd1; in_data = {8{8'hFF}}; end
      endcase
      tick();
      if (t == 2) begin
        check("sel_beat0", 32'(out_data), 32'hA7);
        check("sel_sel0",  32'(out_sel),  32'd7);
      end else if (t == 3) begin
        check("sel_beat1", 32'(out_data), 32'hB0);
        check("sel_sel1",  32'(out_sel),  32'd0);
      end else if (t == 4) begin
        check("sel_beat2", 32'(out_data), 32'hC5);
        check("sel_sel2",  32'(out_sel),  32'd5);
      end
    end
    tick();
    check("sel_drained", 32'(out_valid), 32'd0);

    // Mid-stream reset drops in-flight beats
    out_ready = 1'b0;
    for (int t = 0; t < 3; t++) begin
      in_valid = 1'b1;
      in_sel   = 3'(t + 1);
      in_data  = pack(8'hD0);
      tick();
    end
    in_valid = 1'b0;
    check("mr_full", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_valid_cleared", 32'(out_valid), 32'd0);
    check("mr_data_cleared",  32'(out_data),  32'h00);
    check("mr_in_ready",      32'(in_ready),  32'd1);
    out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      check("mr_no_ghost", 32'(out_valid), 32'd0);
    end

`ifdef MUXTREE_PARITY_EN
    // Parity: 0x07 has three ones, 0x03 has two
    for (int t = 0; t < 4; t++) begin
      in_valid = (t < 2);
      in_sel   = (t == 0) ? 3'd7 : 3'd3;
      in_data  = pack(8'h00);
      tick();
      if (t == 2) begin
        check("par_data0", 32'(out_data), 32'h07);
        check("par_odd",   32'(out_par),  32'd1);
      end else if (t == 3) begin
        check("par_data1", 32'(out_data), 32'h03);
        check("par_even",  32'(out_par),  32'd0);
      end
    end
    in_valid = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
